// File: rtl/hc595_ctrl_if.sv
// Signal bundle between the dynamic-scan stage and the 74HC595 chain driver.
// The scan stage is the master (drives sel/seg); the controller is the slave.
interface hc595_ctrl_if;
    logic [7:0] sel;
    logic [7:0] seg;
    logic       ds;
    logic       shcp;
    logic       stcp;
    logic       oe_n;
    logic       busy;

    modport master (output sel, output seg, input ds, input shcp, input stcp, input oe_n, input busy);
    modport slave  (input sel, input seg, output ds, output shcp, output stcp, output oe_n, output busy);
endinterface

// File: rtl/hc595_ctrl.sv
// Serialises {seg,sel} MSB first into a 74HC595 chain and latches it with stcp.
// A frame is sent only when the word changes, plus once after every reset.
module hc595_ctrl #(
    parameter int HALF = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    hc595_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [8:0] PH_HIGH      = 9'(HALF);
    localparam logic [8:0] PH_LAST      = 9'(2 * HALF - 1);
    localparam logic [8:0] PH_LATCH_END = 9'(HALF - 1);

    state_t      r_state,      w_state_nxt;
    logic [3:0]  r_bit_cnt,    w_bit_cnt_nxt;
    logic [8:0]  r_ph,         w_ph_nxt;
    logic [15:0] r_snapshot,   w_snapshot_nxt;
    logic [15:0] r_last_word,  w_last_word_nxt;
    logic        r_first_flag, w_first_flag_nxt;
    logic        r_ds,         w_ds_nxt;
    logic        r_shcp,       w_shcp_nxt;
    logic        r_stcp,       w_stcp_nxt;
    logic        r_oe_n,       w_oe_n_nxt;
    logic        r_busy,       w_busy_nxt;

    logic [15:0] w_word;
    logic        w_start;
    logic        w_bit_end;
    logic        w_last_bit;
    logic        w_latch_end;

    assign w_word      = {bus.seg, bus.sel};
    assign w_start     = (w_word != r_last_word) || r_first_flag;
    assign w_bit_end   = (r_ph == PH_LAST);
    assign w_last_bit  = (r_bit_cnt == 4'd15);
    assign w_latch_end = (r_ph == PH_LATCH_END);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 4'd0;
            r_ph         <= 9'd0;
            r_snapshot   <= 16'd0;
            r_last_word  <= 16'd0;
            r_first_flag <= 1'b1;
            r_ds         <= 1'b0;
            r_shcp       <= 1'b0;
            r_stcp       <= 1'b0;
            r_oe_n       <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_ph         <= w_ph_nxt;
            r_snapshot   <= w_snapshot_nxt;
            r_last_word  <= w_last_word_nxt;
            r_first_flag <= w_first_flag_nxt;
            r_ds         <= w_ds_nxt;
            r_shcp       <= w_shcp_nxt;
            r_stcp       <= w_stcp_nxt;
            r_oe_n       <= w_oe_n_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = SHIFT;
            SHIFT:   if (w_bit_end && w_last_bit) w_state_nxt = LATCH;
            LATCH:   if (w_latch_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: every signal gets a hold default up front, so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_bit_cnt_nxt    = r_bit_cnt;
        w_ph_nxt         = r_ph;
        w_snapshot_nxt   = r_snapshot;
        w_last_word_nxt  = r_last_word;
        w_first_flag_nxt = r_first_flag;
        w_ds_nxt         = r_ds;
        w_shcp_nxt       = r_shcp;
        w_stcp_nxt       = r_stcp;
        w_oe_n_nxt       = r_oe_n;
        w_busy_nxt       = r_busy;
        case (r_state)
            IDLE: begin
                w_shcp_nxt = 1'b0;
                w_stcp_nxt = 1'b0;
                if (w_start) begin
                    w_snapshot_nxt = w_word;
                    w_bit_cnt_nxt  = 4'd0;
                    w_ph_nxt       = 9'd0;
                    w_ds_nxt       = w_word[15];
                    w_busy_nxt     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_bit_end) begin
                    w_shcp_nxt = 1'b0;
                    w_ph_nxt   = 9'd0;
                    if (!w_last_bit) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        w_ds_nxt      = r_snapshot[4'd14 - r_bit_cnt];
                    end else begin
                        w_stcp_nxt = 1'b1;
                    end
                end else begin
                    // shcp goes high once the phase counter reaches the second half-period
                    w_ph_nxt   = r_ph + 9'd1;
                    w_shcp_nxt = (r_ph + 9'd1) >= PH_HIGH;
                end
            end
            LATCH: begin
                if (w_latch_end) begin
                    w_stcp_nxt       = 1'b0;
                    w_ph_nxt         = 9'd0;
                    w_last_word_nxt  = r_snapshot;
                    w_first_flag_nxt = 1'b0;
                    w_oe_n_nxt       = 1'b0;
                    w_busy_nxt       = 1'b0;
                end else begin
                    w_ph_nxt = r_ph + 9'd1;
                end
            end
            default: begin
                w_shcp_nxt = 1'b0;
                w_stcp_nxt = 1'b0;
            end
        endcase
    end

    assign bus.ds   = r_ds;
    assign bus.shcp = r_shcp;
    assign bus.stcp = r_stcp;
    assign bus.oe_n = r_oe_n;
    assign bus.busy = r_busy;
endmodule

// File: tb/tb_hc595_ctrl.sv
// Bench for hc595_ctrl: HALF=2 and HALF=1 instances share stimulus; each is
// compared every cycle against a frame-offset model, plus directed frame checks.
module tb_hc595_ctrl;
    localparam int SCAN_STEP = 7500;
    localparam int WAIT_MAX  = 5000;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [7:0] tb_seg  = 8'h00;
    logic [7:0] tb_sel  = 8'h00;
    logic [15:0] w_word;
    logic [1:0] v_ds, v_shcp, v_stcp, v_oe_n, v_busy;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         cmp_en   = 1'b0;

    always #10 sys_clk = ~sys_clk;
    assign w_word = {tb_seg, tb_sel};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int H = (g == 0) ? 2 : 1;
        hc595_ctrl_if bus ();
        assign bus.sel = tb_sel;
        assign bus.seg = tb_seg;
        hc595_ctrl #(.HALF(H)) u_dut (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .bus     (bus)
        );
        assign v_ds[g]   = bus.ds;
        assign v_shcp[g] = bus.shcp;
        assign v_stcp[g] = bus.stcp;
        assign v_oe_n[g] = bus.oe_n;
        assign v_busy[g] = bus.busy;
    end

    function automatic int half_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is just (word, k = cycles since start edge); outputs follow by arithmetic.
    bit          m_active  [2];
    int          m_k       [2];
    logic [15:0] m_word    [2];
    logic [15:0] m_last    [2];
    bit          m_first   [2];
    logic        m_idle_ds [2];
    logic        m_oe_n    [2];

    always @(posedge sys_clk or posedge sys_rst) begin
        for (int i = 0; i < 2; i++) begin
            if (sys_rst) begin
                m_active[i]  <= 1'b0;
                m_k[i]       <= 0;
                m_word[i]    <= 16'd0;
                m_last[i]    <= 16'd0;
                m_first[i]   <= 1'b1;
                m_idle_ds[i] <= 1'b0;
                m_oe_n[i]    <= 1'b1;
            end else if (!m_active[i]) begin
                if (w_word != m_last[i] || m_first[i]) begin
                    m_active[i] <= 1'b1;
                    m_k[i]      <= 0;
                    m_word[i]   <= w_word;
                end
            end else if (m_k[i] == 33 * half_of(i) - 1) begin
                m_active[i]  <= 1'b0;
                m_last[i]    <= m_word[i];
                m_first[i]   <= 1'b0;
                m_oe_n[i]    <= 1'b0;
                m_idle_ds[i] <= m_word[i][0];
            end else begin
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    function automatic logic [4:0] expect_vec(input int i);
        int h;
        h = half_of(i);
        if (!m_active[i])
            return {m_idle_ds[i], 1'b0, 1'b0, m_oe_n[i], 1'b0};
        if (m_k[i] < 32 * h)
            return {m_word[i][15 - m_k[i] / (2 * h)], 1'((m_k[i] % (2 * h)) >= h), 1'b0, m_oe_n[i], 1'b1};
        return {m_word[i][0], 1'b0, 1'b1, m_oe_n[i], 1'b1};
    endfunction

    function automatic logic [4:0] out_vec(input int i);
        return {v_ds[i], v_shcp[i], v_stcp[i], v_oe_n[i], v_busy[i]};
    endfunction

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++)
                check((i == 0) ? "H2 cycle {ds,shcp,stcp,oe_n,busy}" : "H1 cycle {ds,shcp,stcp,oe_n,busy}",
                      32'(out_vec(i)), 32'(expect_vec(i)));
        end
    end

    // Per-frame observations of the DUT pins, gathered on the falling edge.
    int          mon_cyc = 0;
    logic [1:0]  mon_prev_shcp = 2'b00, mon_prev_stcp = 2'b00, mon_prev_busy = 2'b00;
    int          mon_start[2], mon_nshcp[2], mon_stcp_off[2], mon_stcp_w[2];
    int          mon_per_min[2], mon_per_max[2], mon_last_rise[2];
    int          mon_frames[2] = '{0, 0};
    int          mon_tot_shcp[2] = '{0, 0};
    int          mon_tot_stcp[2] = '{0, 0};
    int          mon_busy_cyc[2] = '{0, 0};
    logic [15:0] mon_dsseq[2];

    always @(negedge sys_clk) begin
        mon_cyc <= mon_cyc + 1;
        for (int i = 0; i < 2; i++) begin
            mon_prev_shcp[i] <= v_shcp[i];
            mon_prev_stcp[i] <= v_stcp[i];
            mon_prev_busy[i] <= v_busy[i];
            if (v_busy[i] && !mon_prev_busy[i]) begin
                mon_start[i]     <= mon_cyc;
                mon_nshcp[i]     <= 0;
                mon_dsseq[i]     <= 16'd0;
                mon_stcp_off[i]  <= -1;
                mon_stcp_w[i]    <= 0;
                mon_per_min[i]   <= 1000;
                mon_per_max[i]   <= 0;
                mon_last_rise[i] <= -1;
            end else begin
                if (v_shcp[i] && !mon_prev_shcp[i]) begin
                    mon_nshcp[i]     <= mon_nshcp[i] + 1;
                    mon_dsseq[i]     <= {mon_dsseq[i][14:0], v_ds[i]};
                    mon_tot_shcp[i]  <= mon_tot_shcp[i] + 1;
                    mon_last_rise[i] <= mon_cyc;
                    if (mon_last_rise[i] >= 0) begin
                        if (mon_cyc - mon_last_rise[i] < mon_per_min[i]) mon_per_min[i] <= mon_cyc - mon_last_rise[i];
                        if (mon_cyc - mon_last_rise[i] > mon_per_max[i]) mon_per_max[i] <= mon_cyc - mon_last_rise[i];
                    end
                end
                if (v_stcp[i] && !mon_prev_stcp[i]) begin
                    mon_stcp_off[i] <= mon_cyc - mon_start[i];
                    mon_tot_stcp[i] <= mon_tot_stcp[i] + 1;
                end
                if (v_stcp[i]) mon_stcp_w[i] <= mon_stcp_w[i] + 1;
            end
            if (!v_busy[i] && mon_prev_busy[i] && !sys_rst) mon_frames[i] <= mon_frames[i] + 1;
            if (v_busy[i]) mon_busy_cyc[i] <= mon_busy_cyc[i] + 1;
        end
    end

    task automatic wait_done(input int i, input int target, input string name);
        int n;
        n = 0;
        while (!(mon_frames[i] >= target && !mon_prev_busy[i]) && n < WAIT_MAX) begin
            @(posedge sys_clk);
            n++;
        end
        if (n >= WAIT_MAX) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: frame %0d not completed after %0d cycles", name, target, n);
        end
    endtask

    task automatic wait_bit(input int i, input int bits, input string name);
        int n;
        n = 0;
        while (!(mon_prev_busy[i] && mon_nshcp[i] >= bits) && n < WAIT_MAX) begin
            @(posedge sys_clk);
            n++;
        end
        if (n >= WAIT_MAX) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: bit %0d not reached after %0d cycles", name, bits, n);
        end
    endtask

    task automatic check_frame(input int i, input logic [15:0] word, input string tag);
        int h;
        h = half_of(i);
        check($sformatf("%s H%0d shcp rises", tag, h), mon_nshcp[i], 16);
        check($sformatf("%s H%0d ds sequence", tag, h), 32'(mon_dsseq[i]), 32'(word));
        check($sformatf("%s H%0d stcp rise offset", tag, h), mon_stcp_off[i], 32 * h);
        check($sformatf("%s H%0d stcp width", tag, h), mon_stcp_w[i], h);
        check($sformatf("%s H%0d shcp min period", tag, h), mon_per_min[i], 2 * h);
        check($sformatf("%s H%0d shcp max period", tag, h), mon_per_max[i], 2 * h);
    endtask

    task automatic pulse_reset(input int cycles);
        #3 sys_rst = 1'b1;
        repeat (cycles) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    int snap_a[2], snap_b[2], snap_c[2], f0[2];

    initial begin
        tb_seg = 8'hC0;
        tb_sel = 8'h01;
        #1 sys_rst = 1'b1;
        cmp_en = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("reset H%0d outputs", half_of(i)), 32'(out_vec(i)), 32'b00010);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // First frame after reset: C001.
        for (int i = 0; i < 2; i++) wait_done(i, 1, "first frame");
        #1;
        for (int i = 0; i < 2; i++) begin
            check_frame(i, 16'hC001, "first");
            check($sformatf("first H%0d oe_n", half_of(i)), 32'(v_oe_n[i]), 0);
        end

        // Constant inputs: no further activity.
        for (int i = 0; i < 2; i++) begin
            snap_a[i] = mon_tot_shcp[i];
            snap_b[i] = mon_tot_stcp[i];
            snap_c[i] = mon_busy_cyc[i];
        end
        repeat (200) @(posedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("quiet H%0d shcp rises", half_of(i)), mon_tot_shcp[i], snap_a[i]);
            check($sformatf("quiet H%0d stcp rises", half_of(i)), mon_tot_stcp[i], snap_b[i]);
            check($sformatf("quiet H%0d busy cycles", half_of(i)), mon_busy_cyc[i], snap_c[i]);
        end

        // sel changes mid-frame: old word completes, then exactly one new frame.
        for (int i = 0; i < 2; i++) f0[i] = mon_frames[i];
        #1 tb_seg = 8'h3C;
        wait_bit(0, 5, "mid-frame change");
        #1 tb_sel = 8'h02;
        wait_done(0, f0[0] + 1, "old-word frame");
        check("change H2 in-flight ds sequence", 32'(mon_dsseq[0]), 32'h3C01);
        wait_done(0, f0[0] + 2, "new-word frame");
        check("change H2 follow-up ds sequence", 32'(mon_dsseq[0]), 32'h3C02);
        repeat (300) @(posedge sys_clk);
        for (int i = 0; i < 2; i++) check($sformatf("change H%0d frame count", half_of(i)), mon_frames[i], f0[i] + 2);
        check("change H1 last ds sequence", 32'(mon_dsseq[1]), 32'h3C02);

        // Reset at bit 9 aborts, then the frame restarts from bit 0.
        @(posedge sys_clk);
        #1 tb_seg = 8'h5A;
        tb_sel = 8'h81;
        wait_bit(0, 9, "reset abort");
        #3 sys_rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("abort H%0d outputs", half_of(i)), 32'(out_vec(i)), 32'b00010);
        snap_a[0] = mon_tot_shcp[0];
        repeat (5) @(posedge sys_clk);
        check("abort H2 no shcp in reset", mon_tot_shcp[0], snap_a[0]);
        for (int i = 0; i < 2; i++) f0[i] = mon_frames[i];
        #1 sys_rst = 1'b0;
        for (int i = 0; i < 2; i++) wait_done(i, f0[i] + 1, "restart frame");
        #1;
        for (int i = 0; i < 2; i++) check_frame(i, 16'h5A81, "restart");

        // Fresh reset with FF80.
        @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        tb_seg = 8'hFF;
        tb_sel = 8'h80;
        for (int i = 0; i < 2; i++) f0[i] = mon_frames[i];
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        for (int i = 0; i < 2; i++) wait_done(i, f0[i] + 1, "FF80 frame");
        #1;
        for (int i = 0; i < 2; i++) check_frame(i, 16'hFF80, "ff80");

        // Random words, hold times and occasional resets.
        for (int it = 0; it < 60; it++) begin
            @(posedge sys_clk);
            #1;
            if ($urandom_range(0, 3) != 0) begin
                tb_seg = 8'($urandom);
                tb_sel = 8'($urandom);
            end
            if ($urandom_range(0, 11) == 0) pulse_reset($urandom_range(1, 3));
            repeat ($urandom_range(1, 90)) @(posedge sys_clk);
        end

        // Eight-digit scan, one sel step per scan period.
        @(posedge sys_clk);
        #1 tb_seg = 8'h00;
        tb_sel = 8'h00;
        repeat (200) @(posedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            f0[i] = mon_frames[i];
            snap_c[i] = mon_busy_cyc[i];
        end
        for (int d = 0; d < 8; d++) begin
            #1 tb_sel = 8'(1 << d);
            tb_seg = 8'($urandom);
            repeat (SCAN_STEP) @(posedge sys_clk);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("scan H%0d frames", half_of(i)), mon_frames[i] - f0[i], 8);
            check($sformatf("scan H%0d busy duty below 1%%", half_of(i)),
                  32'(((mon_busy_cyc[i] - snap_c[i]) * 100) < (8 * SCAN_STEP)), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hc595_ctrl.md
HC595_CTRL -- requirements
Module: hc595_ctrl

Interface
REQ-001 SHALL have parameter HALF, default 2: sys_clk cycles per shcp half-period; legal range 1..255.
REQ-002 SHALL have port sys_clk, input, 1 bit: system clock, 50 MHz, all logic on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port sel, input, 8 bits: digit-select pattern from the dynamic-scan stage.
REQ-005 SHALL have port seg, input, 8 bits: segment pattern from the dynamic-scan stage, dot in bit 7, active-low.
REQ-006 SHALL have port ds, output, 1 bit: serial data to the 74HC595 chain.
REQ-007 SHALL have port shcp, output, 1 bit: shift-register clock to the 595 chain.
REQ-008 SHALL have port stcp, output, 1 bit: storage-register latch clock to the 595 chain.
REQ-009 SHALL have port oe_n, output, 1 bit: 595 output enable, active-low.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is being shifted or latched.

Function
REQ-011 SHALL implement a three-state machine: IDLE, SHIFT, LATCH; every output is a registered signal.
REQ-012 SHALL define the frame word as {seg[7:0], sel[7:0]}, 16 bits, shifted MSB first, so seg[7] goes out first and sel[0] goes out last.
REQ-013 In IDLE, SHALL start a frame when {seg,sel} differs from last_word, or when first_flag is set.
REQ-014 On frame start, SHALL: capture {seg,sel} into snapshot, set bit_cnt=0 and ph=0, drive ds=seg[7] and shcp=0, set busy=1, and enter SHIFT, all in the same edge.
REQ-015 Input changes after the snapshot edge SHALL NOT affect the frame in progress; they are evaluated only on the next return to IDLE.
REQ-016 In SHIFT, ph SHALL count 0..2*HALF-1 per bit: shcp low while ph<HALF, high while ph>=HALF, so shcp rises HALF cycles after the ds update.
REQ-017 When ph=2*HALF-1 and bit_cnt<15, SHALL: drive shcp=0, increment bit_cnt, set ds=snapshot[15-bit_cnt-1], and set ph=0.
REQ-018 When ph=2*HALF-1 and bit_cnt=15, SHALL: drive shcp=0 and stcp=1, and enter LATCH with ph=0.
REQ-019 ds SHALL be stable throughout each shcp high phase; the shift-clock duty cycle is exactly 50%.
REQ-020 In LATCH, stcp SHALL stay high for exactly HALF cycles.
REQ-021 On leaving LATCH, SHALL in one edge: drive stcp=0, set last_word=snapshot, clear first_flag, drive oe_n=0, set busy=0, and enter IDLE.
REQ-022 IDLE SHALL last at least one cycle between frames.
REQ-023 Frame length SHALL be 32*HALF SHIFT cycles plus HALF LATCH cycles; the stcp rising edge occurs 32*HALF cycles after the frame-start edge.
REQ-024 Once low, oe_n SHALL remain low until reset, so outputs are never enabled before the first complete latch.
REQ-025 In IDLE, ds SHALL hold its last value and shcp=stcp=0.
REQ-026 bit_cnt SHALL be 4 bits wide; ph SHALL be 9 bits wide with no wrap beyond 2*HALF-1.

Reset
REQ-027 While sys_rst=1, SHALL force: state=IDLE, ds=0, shcp=0, stcp=0, oe_n=1, busy=0, bit_cnt=0, ph=0, snapshot=0, last_word=0, first_flag=1.
REQ-028 Assertion of sys_rst mid-SHIFT or mid-LATCH SHALL abort the frame immediately with no further shcp or stcp edges.
REQ-029 After sys_rst deasserts, the first IDLE cycle SHALL start a frame regardless of the input value, because first_flag=1.

Verification
REQ-030 Scenario, HALF=2: release reset with seg=8'hC0, sel=8'h01 -> 16 shcp rising edges, ds sequence 1100_0000_0000_0001, stcp high 2 cycles at cycle 64 after frame start, then oe_n=0.
REQ-031 Scenario: hold inputs constant after the first frame -> no further shcp or stcp activity and busy stays 0.
REQ-032 Scenario: change sel to 8'h02 at bit 5 of a frame -> current frame still shifts the old word; exactly one following frame shifts {seg,8'h02}.
REQ-033 Scenario: assert sys_rst at bit 9 -> shcp, stcp, ds go to 0 and oe_n to 1 asynchronously; after release, a full frame restarts from bit 0.
REQ-034 Scenario, HALF=1: seg=8'hFF, sel=8'h80 -> shcp period 2 cycles, stcp pulse 1 cycle, stcp rise 32 cycles after frame start.
REQ-035 Scenario: an 8-digit scan driven by the dynamic-scan stage, with sel stepping every 1 ms -> one frame per sel change and busy duty below 1%.
